// File: rtl/song_sequencer.sv
// song_sequencer: walks a 4 x 32 synchronous-read song ROM and hands (note, duration)
// pairs to the note player, one load strobe per entry, waiting for the player in between.
module song_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        note_done,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [5:0]  note_to_load,
  output logic [5:0]  duration_to_load,
  output logic        load_new_note,
  output logic        song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    ISSUE,
    GUARD,
    WAIT,
    END,
    HOLD
  } state_t;

  state_t      state_reg;
  logic [1:0]  song_q_reg;
  logic [4:0]  note_idx_reg;
  logic        last_reg;

  assign rom_addr = {song_q_reg, note_idx_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      song_q_reg       <= 2'd0;
      note_idx_reg     <= 5'd0;
      last_reg         <= 1'b0;
      note_to_load     <= 6'd0;
      duration_to_load <= 6'd0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      // Strobes are set on the transition into ISSUE / END so they last one cycle.
      load_new_note <= 1'b0;
      song_done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (play && note_done) begin
            song_q_reg   <= song;
            note_idx_reg <= 5'd0;
            last_reg     <= 1'b0;
            state_reg    <= FETCH;
          end
        end
        FETCH: state_reg <= DATA;
        DATA: begin
          if (rom_data[5:0] == 6'd0) begin
            song_done <= 1'b1;
            state_reg <= END;
          end else begin
            note_to_load     <= rom_data[11:6];
            duration_to_load <= rom_data[5:0];
            load_new_note    <= 1'b1;
            state_reg        <= ISSUE;
          end
        end
        ISSUE: begin
          last_reg     <= (note_idx_reg == 5'd31);
          note_idx_reg <= note_idx_reg + 5'd1;
          state_reg    <= GUARD;
        end
        // The player still reports done while capturing the load, so skip one cycle.
        GUARD: state_reg <= WAIT;
        WAIT: begin
          if (note_done && play) begin
            if (last_reg) begin
              song_done <= 1'b1;
              state_reg <= END;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        END: begin
          note_idx_reg <= 5'd0;
          state_reg    <= HOLD;
        end
        HOLD: begin
          if (!play) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: ROM and note-player models around the DUT, randomized play/song/reset
// activity, checked against a transaction-level timing model of the song walk.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done = 1'b1;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        song_done;

  song_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: where the song walk is, and at which edge the next event is due.
  typedef enum {M_IDLE, M_RUN, M_WAIT, M_HOLD} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          k = 0;
  int          m_arm = 0, m_event = 0, m_song = 0, m_idx = 0, exp_addr = 0;
  logic [5:0]  m_note = 6'd0, m_dur = 6'd0;
  logic        exp_load, exp_done;

  // Stimulus controls and observation counters.
  int  rem = 0;
  logic load_seen = 1'b0;
  bit  done_force = 0, pause_en = 0, rand_song = 0, inject_en = 0, hold_drop = 0, gap_chk = 0;
  int  n_strobes = 0, n_dones = 0, last_strobe_k = -1;

  task automatic model_reset();
    m_phase = M_IDLE; m_arm = 0; m_idx = 0; m_song = 0;
    m_note = 6'd0; m_dur = 6'd0;
  endtask

  task automatic cycle();
    logic p, d, r;
    logic [1:0] s;
    logic [11:0] entry;
    p = play; d = note_done; r = reset; s = song;
    @(posedge clk);
    #1;
    k++;
    exp_load = 1'b0;
    exp_done = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      case (m_phase)
        M_IDLE: if (k >= m_arm && p && d) begin
          m_song = int'(s); m_idx = 0; m_event = k + 2; m_phase = M_RUN;
        end
        M_RUN: if (k == m_event) begin
          entry = rom[m_song * 32 + m_idx];
          if (entry[5:0] == 6'd0) begin
            exp_done = 1'b1; m_idx = 0; m_phase = M_HOLD; m_arm = k + 2;
          end else begin
            exp_load = 1'b1; m_note = entry[11:6]; m_dur = entry[5:0];
            exp_addr = m_song * 32 + m_idx;
            m_idx++; m_phase = M_WAIT; m_arm = k + 3;
          end
        end
        M_WAIT: if (k >= m_arm && p && d) begin
          if (m_idx == 32) begin
            exp_done = 1'b1; m_idx = 0; m_phase = M_HOLD; m_arm = k + 2;
          end else begin
            m_event = k + 2; m_phase = M_RUN;
          end
        end
        M_HOLD: if (k >= m_arm && !p) begin
          m_phase = M_IDLE; m_arm = k + 1;
        end
        default: ;
      endcase
    end
    check("load_new_note", load_new_note, exp_load);
    check("song_done", song_done, exp_done);
    check("note_to_load", note_to_load, m_note);
    check("duration_to_load", duration_to_load, m_dur);
    if (exp_load) check("strobe_addr", rom_addr, exp_addr);
    if (m_phase == M_HOLD && k >= m_arm) check("hold_addr", rom_addr, m_song * 32);
    if (load_new_note) begin
      if (gap_chk && last_strobe_k >= 0) check("strobe_gap", k - last_strobe_k, 5);
      last_strobe_k = k;
      n_strobes++;
    end
    if (song_done) n_dones++;

    // Note player: captures the load one edge after the strobe, then counts beats down.
    if (load_seen) rem = int'(duration_to_load);
    else if (rem > 0) rem--;
    load_seen = load_new_note;
    note_done = done_force ? 1'b1 : (rem == 0);

    if (r) reset = 1'b0;
    if (!play) play = ($urandom_range(0, 3) == 0);
    else if (hold_drop && m_phase == M_HOLD && $urandom_range(0, 3) == 0) play = 1'b0;
    else if (pause_en && $urandom_range(0, 19) == 0) play = 1'b0;
    if (rand_song) song = 2'($urandom);

    if (inject_en && exp_load && $urandom_range(0, 3) == 0) begin
      #1 reset = 1'b1;
      #1;
      check("rst_load", load_new_note, 1'b0);
      check("rst_note", note_to_load, 6'd0);
      check("rst_dur", duration_to_load, 6'd0);
      check("rst_song_done", song_done, 1'b0);
      check("rst_addr", rom_addr, 7'd0);
      model_reset();
      load_seen = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      logic [5:0] dur;
      dur = 6'($urandom_range(0, 7));
      if (i >= 96) dur = 6'($urandom_range(1, 3));
      rom[i] = {6'($urandom), dur};
    end
    rom[32] = {6'd12, 6'd4};
    rom[33] = {6'd20, 6'd2};
    rom[34] = {6'd7,  6'd1};
    rom[35] = {6'd55, 6'd0};

    #1 reset = 1'b1;
    #1;
    check("reset_load", load_new_note, 1'b0);
    check("reset_song_done", song_done, 1'b0);
    check("reset_addr", rom_addr, 7'd0);
    check("reset_note", note_to_load, 6'd0);
    check("reset_dur", duration_to_load, 6'd0);
    run(2);
    reset = 1'b0;

    // Basic three-note song with a real player.
    song = 2'd1; play = 1'b1;
    n_strobes = 0; n_dones = 0;
    run(50);
    check("basic_strobes", n_strobes, 3);
    check("basic_dones", n_dones, 1);
    play = 1'b0;
    run(3);

    // Full 32-entry song with note_done stuck high: exact 5-cycle spacing.
    song = 2'd3; play = 1'b1; done_force = 1; gap_chk = 1;
    n_strobes = 0; n_dones = 0; last_strobe_k = -1;
    run(180);
    check("full_strobes", n_strobes, 32);
    check("full_dones", n_dones, 1);
    gap_chk = 0;
    run(10);
    check("hold_no_strobe", n_strobes, 32);
    play = 1'b0;
    run(1);
    play = 1'b1;
    run(12);
    check("restart_strobes", n_strobes, 34);

    // Randomized play, song select, player mode and mid-issue resets.
    pause_en = 1; rand_song = 1; inject_en = 1; hold_drop = 1;
    for (int blk = 0; blk < 15; blk++) begin
      done_force = ($urandom_range(0, 3) == 0);
      run(200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
